// File: rtl/tx_code_group_sequencer.sv
// tx_code_group_sequencer: expands PCS ordered sets (/I/, /C/, /S/, /D/, /T/, /R/) into one
// code-group per gtx_clk with K flag, even-slot tracking and ordered-set boundary indication.
module tx_code_group_sequencer #(
  parameter int TX_O_SET_WIDTH = 5,
  parameter logic [TX_O_SET_WIDTH-1:0] I_OS = TX_O_SET_WIDTH'(0),
  parameter logic [TX_O_SET_WIDTH-1:0] S_OS = TX_O_SET_WIDTH'(1),
  parameter logic [TX_O_SET_WIDTH-1:0] D_OS = TX_O_SET_WIDTH'(2),
  parameter logic [TX_O_SET_WIDTH-1:0] T_OS = TX_O_SET_WIDTH'(3),
  parameter logic [TX_O_SET_WIDTH-1:0] R_OS = TX_O_SET_WIDTH'(4)
) (
  input  logic                      gtx_clk,
  input  logic                      mr_main_reset,
  input  logic [1:0]                xmit,
  input  logic [15:0]               tx_config_reg,
  input  logic [TX_O_SET_WIDTH-1:0] tx_o_set,
  input  logic [7:0]                txd,
  input  logic                      tx_disparity_pos,
  output logic                      tx_even,
  output logic                      tx_oset_indicate,
  output logic [7:0]                tx_cg_octet,
  output logic                      tx_cg_is_k
);
  typedef enum logic [2:0] {IDLE_K, IDLE_D, CFG_K, CFG_D, CFG_LO, CFG_HI, SINGLE, ALIGN} state_t;

  state_t      state_q, state_d, sel, cur;
  logic        first_q, even_q, ind_q, ind_d, k_q, k_d, rd_q, rd_d, csel_q, csel_d;
  logic        boundary, is_cfg, is_idle, s_k;
  logic [7:0]  oct_q, oct_d, s_oct;
  logic [15:0] cfg_q, cfg_d;

  // cur is the state whose code-group goes out on this edge; a boundary overrides the stored state
  always_comb begin
    boundary = ind_q | first_q;
    is_cfg   = xmit == 2'b01;
    is_idle  = !is_cfg && (xmit != 2'b10 || tx_o_set == I_OS);
    sel      = (is_cfg || is_idle) ? (even_q ? ALIGN : (is_cfg ? CFG_K : IDLE_K)) : SINGLE;
    cur      = boundary ? sel : state_q;
    s_oct    = tx_o_set == S_OS ? 8'hFB : tx_o_set == D_OS ? txd :
               tx_o_set == T_OS ? 8'hFD : tx_o_set == R_OS ? 8'hF7 : 8'hFE;
    s_k      = tx_o_set != D_OS;
    state_d  = IDLE_K;
    oct_d    = 8'hBC;
    k_d      = 1'b1;
    case (cur)
      IDLE_K: state_d = IDLE_D;
      IDLE_D: begin state_d = IDLE_K; oct_d = rd_q ? 8'hC5 : 8'h50; k_d = 1'b0; end
      CFG_K:  state_d = CFG_D;
      CFG_D:  begin state_d = CFG_LO; oct_d = csel_q ? 8'h42 : 8'hB5; k_d = 1'b0; end
      CFG_LO: begin state_d = CFG_HI; oct_d = cfg_q[7:0]; k_d = 1'b0; end
      CFG_HI: begin state_d = CFG_K; oct_d = cfg_q[15:8]; k_d = 1'b0; end
      SINGLE: begin state_d = SINGLE; oct_d = s_oct; k_d = s_k; end
      default: begin state_d = is_cfg ? CFG_K : IDLE_K; oct_d = 8'hF7; end
    endcase
    ind_d  = cur == IDLE_D || cur == CFG_HI || cur == SINGLE;
    rd_d   = cur == IDLE_K ? tx_disparity_pos : rd_q;
    cfg_d  = cur == CFG_K ? tx_config_reg : cfg_q;
    csel_d = boundary && !is_cfg ? 1'b0 : cur == CFG_HI ? ~csel_q : csel_q;
  end

  always_ff @(posedge gtx_clk or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      state_q <= IDLE_K;
      first_q <= 1'b1;
      even_q  <= 1'b0;
      ind_q   <= 1'b0;
      oct_q   <= 8'h00;
      k_q     <= 1'b0;
      rd_q    <= 1'b0;
      csel_q  <= 1'b0;
      cfg_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      first_q <= 1'b0;
      even_q  <= ~even_q;
      ind_q   <= ind_d;
      oct_q   <= oct_d;
      k_q     <= k_d;
      rd_q    <= rd_d;
      csel_q  <= csel_d;
      cfg_q   <= cfg_d;
    end
  end

  assign tx_even          = even_q;
  assign tx_oset_indicate = ind_q;
  assign tx_cg_octet      = oct_q;
  assign tx_cg_is_k       = k_q;
endmodule

// File: tb/tb_tx_code_group_sequencer.sv
// tb_tx_code_group_sequencer: directed scoreboard bench; each step queues the expected
// {even, indicate, is_k, octet} and checks it against the code-group produced on that edge.
module tb_tx_code_group_sequencer;
  localparam logic [4:0] I = 5'd0, S = 5'd1, D = 5'd2, T = 5'd3, R = 5'd4, U = 5'd31;
  localparam logic [1:0] XI = 2'b00, XC = 2'b01, XD = 2'b10, X3 = 2'b11;

  logic        gtx_clk = 1'b0;
  logic        mr_main_reset = 1'b0;
  logic [1:0]  xmit = XI;
  logic [15:0] tx_config_reg = 16'h01A0;
  logic [4:0]  tx_o_set = I;
  logic [7:0]  txd = 8'h00;
  logic        tx_disparity_pos = 1'b0;
  logic        tx_even, tx_oset_indicate, tx_cg_is_k;
  logic [7:0]  tx_cg_octet;
  logic [10:0] q[$];
  int          passed = 0, total = 0;

  tx_code_group_sequencer #(.TX_O_SET_WIDTH(5)) dut (
    .gtx_clk(gtx_clk), .mr_main_reset(mr_main_reset), .xmit(xmit),
    .tx_config_reg(tx_config_reg), .tx_o_set(tx_o_set), .txd(txd),
    .tx_disparity_pos(tx_disparity_pos), .tx_even(tx_even),
    .tx_oset_indicate(tx_oset_indicate), .tx_cg_octet(tx_cg_octet), .tx_cg_is_k(tx_cg_is_k)
  );

  always #5 gtx_clk = ~gtx_clk;

  function automatic logic [10:0] e(input logic ev, input logic ind, input logic k, input logic [7:0] o);
    return {ev, ind, k, o};
  endfunction

  function automatic logic [10:0] obs();
    return {tx_even, tx_oset_indicate, tx_cg_is_k, tx_cg_octet};
  endfunction

  task automatic check(input string tag, input logic [10:0] o, input logic [10:0] x);
    total++;
    assert (o === x) passed++;
    else $error("FAIL %s: observed %h expected %h (even,ind,k,octet)", tag, o, x);
  endtask

  task automatic step(input string tag, input logic [1:0] x, input logic [4:0] os, input logic [7:0] d,
                      input logic [10:0] exp);
    xmit = x;
    tx_o_set = os;
    txd = d;
    q.push_back(exp);
    @(posedge gtx_clk);
    #1;
    check(tag, obs(), q.pop_front());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    check("reset_state", obs(), 11'h000);
    @(negedge gtx_clk);
    mr_main_reset = 1'b1;
    // idle with negative disparity: /I2/
    step("idle_k0",  XI, I, 8'h00, e(1, 0, 1, 8'hBC));
    step("idle_d0",  XI, I, 8'h00, e(0, 1, 0, 8'h50));
    step("idle_k1",  XI, I, 8'h00, e(1, 0, 1, 8'hBC));
    step("idle_d1",  XI, I, 8'h00, e(0, 1, 0, 8'h50));
    tx_disparity_pos = 1'b1;
    step("i1_k",     XI, I, 8'h00, e(1, 0, 1, 8'hBC));
    step("i1_d",     XI, I, 8'h00, e(0, 1, 0, 8'hC5));
    tx_disparity_pos = 1'b0;
    step("i2_k",     XI, I, 8'h00, e(1, 0, 1, 8'hBC));
    step("i2_d",     XI, I, 8'h00, e(0, 1, 0, 8'h50));
    // configuration: C1 then C2, config word frozen mid-set
    step("c1_k",     XC, I, 8'h00, e(1, 0, 1, 8'hBC));
    step("c1_d",     XC, I, 8'h00, e(0, 0, 0, 8'hB5));
    step("c1_lo",    XC, I, 8'h00, e(1, 0, 0, 8'hA0));
    step("c1_hi",    XC, I, 8'h00, e(0, 1, 0, 8'h01));
    step("c2_k",     XC, I, 8'h00, e(1, 0, 1, 8'hBC));
    step("c2_d",     XC, I, 8'h00, e(0, 0, 0, 8'h42));
    tx_config_reg = 16'hFFFF;
    step("c2_lo",    XC, I, 8'h00, e(1, 0, 0, 8'hA0));
    step("c2_hi",    XC, I, 8'h00, e(0, 1, 0, 8'h01));
    step("c3_k",     XC, I, 8'h00, e(1, 0, 1, 8'hBC));
    step("c3_d",     XC, I, 8'h00, e(0, 0, 0, 8'hB5));
    step("c3_lo",    XC, I, 8'h00, e(1, 0, 0, 8'hFF));
    step("c3_hi",    XC, I, 8'h00, e(0, 1, 0, 8'hFF));
    // data mode packet
    step("dat_i_k",  XD, I, 8'h00, e(1, 0, 1, 8'hBC));
    step("dat_i_d",  XD, I, 8'h00, e(0, 1, 0, 8'h50));
    step("dat_s",    XD, S, 8'h00, e(1, 1, 1, 8'hFB));
    step("dat_d55",  XD, D, 8'h55, e(0, 1, 0, 8'h55));
    step("dat_dd5",  XD, D, 8'hD5, e(1, 1, 0, 8'hD5));
    step("dat_t",    XD, T, 8'h00, e(0, 1, 1, 8'hFD));
    step("dat_r0",   XD, R, 8'h00, e(1, 1, 1, 8'hF7));
    step("dat_r1",   XD, R, 8'h00, e(0, 1, 1, 8'hF7));
    step("dat_i2_k", XD, I, 8'h00, e(1, 0, 1, 8'hBC));
    step("dat_i2_d", XD, I, 8'h00, e(0, 1, 0, 8'h50));
    // single /R/ puts the next /I/ on an odd slot: alignment K23.7 first
    step("odd_r",    XD, R, 8'h00, e(1, 1, 1, 8'hF7));
    step("align",    XD, I, 8'h00, e(0, 0, 1, 8'hF7));
    step("aln_k",    XC, I, 8'h00, e(1, 0, 1, 8'hBC));
    step("aln_d",    XC, I, 8'h00, e(0, 1, 0, 8'h50));
    tx_config_reg = 16'h01A0;
    step("cr_k",     XC, I, 8'h00, e(1, 0, 1, 8'hBC));
    step("cr_d",     XC, I, 8'h00, e(0, 0, 0, 8'hB5));
    step("cr_lo",    XC, I, 8'h00, e(1, 0, 0, 8'hA0));
    // asynchronous reset in the middle of a /C/ set
    #2;
    mr_main_reset = 1'b0;
    #1;
    check("mid_reset", obs(), 11'h000);
    @(negedge gtx_clk);
    mr_main_reset = 1'b1;
    step("post_k",   XC, I, 8'h00, e(1, 0, 1, 8'hBC));
    step("post_d",   XC, I, 8'h00, e(0, 0, 0, 8'hB5));
    step("post_lo",  XC, I, 8'h00, e(1, 0, 0, 8'hA0));
    step("post_hi",  XC, I, 8'h00, e(0, 1, 0, 8'h01));
    // unknown ordered set, then xmit=3 behaving as IDLE from an odd slot
    step("unknown",  XD, U, 8'h00, e(1, 1, 1, 8'hFE));
    step("x3_align", X3, U, 8'h00, e(0, 0, 1, 8'hF7));
    step("x3_k",     X3, U, 8'h00, e(1, 0, 1, 8'hBC));
    step("x3_d",     X3, U, 8'h00, e(0, 1, 0, 8'h50));
    if (q.size() != 0) begin
      total++;
      $display("FAIL scoreboard_drain: observed %0d leftover expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
